// File: rtl/btb_update_if.sv
// btb_update_if: execute-side bundle between the resolution logic / fetch
// and the BTB write controller.
//   master: drives resolved-branch info, flush_req and the fetch btb_rd,
//           observes the BTB write command and status.
//   slave : the btb_update controller.
// Signals:
//   res_valid/res_pc/res_taken/res_target/res_pred_hit/res_pred_target
//                   resolved branch and what fetch predicted for it
//   flush_req       clear pending updates and re-sweep the BTB
//   btb_rd          fetch read request on the shared BTB port
//   btb_wr/btb_invalid/pc_w/target_pc_w  BTB write command
//   wr_conflict     write and read collided this cycle
//   init_done       BTB contents valid for fetch
//   drop_cnt        saturating count of dropped updates
interface btb_update_if #(
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic [31:1]      res_pc;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             res_pred_hit;
  logic [31:1]      res_pred_target;
  logic             flush_req;
  logic             btb_rd;

  logic             btb_wr;
  logic             btb_invalid;
  logic [31:1]      pc_w;
  logic [31:0]      target_pc_w;
  logic             wr_conflict;
  logic             init_done;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output res_valid, res_pc, res_taken, res_target, res_pred_hit,
           res_pred_target, flush_req, btb_rd,
    input  btb_wr, btb_invalid, pc_w, target_pc_w, wr_conflict,
           init_done, drop_cnt
  );

  modport slave (
    input  res_valid, res_pc, res_taken, res_target, res_pred_hit,
           res_pred_target, flush_req, btb_rd,
    output btb_wr, btb_invalid, pc_w, target_pc_w, wr_conflict,
           init_done, drop_cnt
  );
endinterface

// File: rtl/btb_update.sv
// btb_update: BTB write-side controller in the execute stage.
// Compares each resolved branch with the fetch prediction, queues the
// resulting BTB write/invalidate in a small FIFO, drains the FIFO into the
// single-port BTB when fetch is not reading (or after STARVE_MAX read
// cycles), and sweeps every entry invalid after reset or flush.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      btb_update_if slave modport (resolution in, BTB write out)
//
// state | meaning
// ------+--------------------------------------------------------------
// START | one idle cycle after reset/flush, no BTB write
// INIT  | sweep: invalidate entry sweep_idx each cycle, 0..TAG_DEPTH-1
// RUN   | classify resolutions, queue updates, drain FIFO to the BTB
module btb_update #(
  parameter int TAG_DEPTH   = 256,
  parameter int GROUP_WIDTH = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int STARVE_MAX  = 8,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  btb_update_if.slave  bus
);

  localparam int IDX_W   = $clog2(TAG_DEPTH);
  localparam int IDX_LSB = 1 + GROUP_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ST_W    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_idx;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   wr_ptr;
  logic [ST_W-1:0]  starve_cnt;
  logic [CNT_W-1:0] drop_cnt;

  logic [31:1]      fifo_pc  [FIFO_DEPTH];
  logic [31:0]      fifo_tgt [FIFO_DEPTH];
  logic             fifo_inv [FIFO_DEPTH];

  logic             empty;
  logic             full;
  logic [PTR_W-1:0] head;
  logic             need_upd;
  logic             upd_inv;
  logic [31:0]      upd_tgt;
  logic             run_ok;
  logic             pop;
  logic             push;
  logic             drop;
  logic             wr_c;
  logic             inv_c;
  logic [31:1]      pc_c;
  logic [31:0]      tgt_c;

  assign empty = (rd_ptr == wr_ptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (rd_ptr[PTR_W] != wr_ptr[PTR_W]) &&
                 (rd_ptr[PTR_W-1:0] == wr_ptr[PTR_W-1:0]);
  assign head  = rd_ptr[PTR_W-1:0];

  // Taken: update unless fetch hit with the right target.
  // Not taken: invalidate only if fetch predicted a hit.
  always_comb begin
    need_upd = 1'b0;
    if (bus.res_valid) begin
      if (bus.res_taken)
        need_upd = !bus.res_pred_hit ||
                   (bus.res_target[31:1] != bus.res_pred_target);
      else
        need_upd = bus.res_pred_hit;
    end
  end

  assign upd_inv = !bus.res_taken;
  assign upd_tgt = bus.res_taken ? bus.res_target : 32'h0;

  always_comb begin
    wr_c  = 1'b0;
    inv_c = 1'b0;
    pc_c  = '0;
    tgt_c = '0;
    case (state)
      S_INIT: begin
        wr_c  = 1'b1;
        inv_c = 1'b1;
        pc_c[IDX_LSB +: IDX_W] = sweep_idx;
      end
      S_RUN: begin
        if (!empty) begin
          // Fetch normally wins the port; a starved write is forced through.
          wr_c  = !bus.btb_rd || (starve_cnt == ST_W'(STARVE_MAX));
          inv_c = fifo_inv[head];
          pc_c  = fifo_pc[head];
          tgt_c = fifo_tgt[head];
        end
      end
      default: ;
    endcase
  end

  assign run_ok = (state == S_RUN) && !bus.flush_req;
  assign pop    = (state == S_RUN) && wr_c;
  assign push   = run_ok && need_upd && (!full || pop);
  assign drop   = run_ok && need_upd && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_START;
      sweep_idx  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      starve_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        S_START: begin
          state     <= S_INIT;
          sweep_idx <= '0;
        end
        S_INIT: begin
          if (bus.flush_req) begin
            sweep_idx <= '0;
          end else if (sweep_idx == IDX_W'(TAG_DEPTH - 1)) begin
            state     <= S_RUN;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        S_RUN: begin
          if (bus.flush_req) begin
            state      <= S_START;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            starve_cnt <= '0;
          end else begin
            if (pop)
              rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (push)
              wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (drop && (drop_cnt != '1))
              drop_cnt <= drop_cnt + CNT_W'(1);
            if (pop || empty)
              starve_cnt <= '0;
            else if (bus.btb_rd && (starve_cnt != ST_W'(STARVE_MAX)))
              starve_cnt <= starve_cnt + ST_W'(1);
          end
        end
        default: state <= S_START;
      endcase
    end
  end

  // Entry storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr[PTR_W-1:0]]  <= bus.res_pc;
      fifo_tgt[wr_ptr[PTR_W-1:0]] <= upd_tgt;
      fifo_inv[wr_ptr[PTR_W-1:0]] <= upd_inv;
    end
  end

  assign bus.btb_wr      = wr_c;
  assign bus.btb_invalid = inv_c;
  assign bus.pc_w        = pc_c;
  assign bus.target_pc_w = tgt_c;
  assign bus.wr_conflict = wr_c && bus.btb_rd;
  assign bus.init_done   = (state == S_RUN);
  assign bus.drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_btb_update.sv
module tb_btb_update;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  btb_update_if #(.CNT_W(16)) bus ();

  btb_update dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:1] pc;
    logic [31:0] tgt;
    logic        inv;
    logic        conf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:1] pc, input logic [31:0] tgt,
                          input logic inv, input logic conf);
    exp_t e;
    e.pc = pc; e.tgt = tgt; e.inv = inv; e.conf = conf;
    exp_q.push_back(e);
  endtask

  // Sweep entry i writes pc_w[9:2] = i, i.e. pc_w value i*2.
  task automatic push_sweep(input logic conf, input int n);
    for (int i = 0; i < n; i++)
      push_exp(31'(i * 2), 32'h0, 1'b1, conf);
  endtask

  // Monitor: every BTB write must match the head of the expected queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && bus.btb_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: pc_w=%h tgt=%h inv=%b", bus.pc_w, bus.target_pc_w, bus.btb_invalid);
      end else begin
        e = exp_q.pop_front();
        if (bus.pc_w !== e.pc || bus.target_pc_w !== e.tgt ||
            bus.btb_invalid !== e.inv || bus.wr_conflict !== e.conf) begin
          errors++;
          $display("FAIL write_cmd: got pc=%h tgt=%h inv=%b conf=%b want pc=%h tgt=%h inv=%b conf=%b",
                   bus.pc_w, bus.target_pc_w, bus.btb_invalid, bus.wr_conflict,
                   e.pc, e.tgt, e.inv, e.conf);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_res(input logic v, input logic [31:1] pc, input logic t,
                         input logic [31:0] tgt, input logic h, input logic [31:1] ptgt);
    bus.res_valid = v; bus.res_pc = pc; bus.res_taken = t;
    bus.res_target = tgt; bus.res_pred_hit = h; bus.res_pred_target = ptgt;
  endtask

  // Cycles spent before init_done rises (bounded).
  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.init_done) break;
      n++;
    end
    cyc();
  endtask

  // Cycles spent before the next btb_wr (bounded).
  task automatic wait_wr(output int n);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.btb_wr) break;
      n++;
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_res(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bus.flush_req = 1'b0;
    bus.btb_rd    = 1'b1;

    // Reset state
    repeat (2) cyc();
    check("rst_btb_wr", bus.btb_wr, 0);
    check("rst_pc_w", bus.pc_w, 0);
    check("rst_wr_conflict", bus.wr_conflict, 0);
    check("rst_init_done", bus.init_done, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);

    // Initial sweep: 1 idle + 256 invalidates, then init_done
    bus.btb_rd = 1'b0;
    push_sweep(1'b0, 256);
    reset_n = 1'b1;
    wait_init(n);
    check("init_cycles", n, 257);
    check("sweep_drained", exp_q.size(), 0);

    // Taken, not predicted -> write next cycle
    set_res(1'b1, 31'h2000_0800, 1'b1, 32'h4000_2000, 1'b0, '0);
    push_exp(31'h2000_0800, 32'h4000_2000, 1'b0, 1'b0);
    cyc();
    bus.res_valid = 1'b0;
    @(negedge clk);
    check("wr_latency", bus.btb_wr, 1);
    check("wr_conflict_idle", bus.wr_conflict, 0);
    cyc();

    // Not taken, predicted hit -> invalidate
    set_res(1'b1, 31'h0000_1234, 1'b0, 32'h0000_0000, 1'b1, 31'h0000_5000);
    push_exp(31'h0000_1234, 32'h0, 1'b1, 1'b0);
    cyc();
    bus.res_valid = 1'b0;
    @(negedge clk);
    check("inv_wr", bus.btb_wr, 1);
    cyc();

    // Correctly predicted taken -> nothing
    set_res(1'b1, 31'h0000_0800, 1'b1, 32'h4000_2000, 1'b1, 31'h2000_1000);
    cyc();
    bus.res_valid = 1'b0;
    @(negedge clk);
    check("no_wr_correct_pred", bus.btb_wr, 0);
    cyc();

    // Not taken, not predicted -> nothing
    set_res(1'b1, 31'h0000_0888, 1'b0, 32'h0000_1000, 1'b0, '0);
    cyc();
    bus.res_valid = 1'b0;
    @(negedge clk);
    check("no_wr_nt_miss", bus.btb_wr, 0);
    cyc();

    // Hit with wrong target -> write
    set_res(1'b1, 31'h0000_0A00, 1'b1, 32'h4000_3000, 1'b1, 31'h2000_1000);
    push_exp(31'h0000_0A00, 32'h4000_3000, 1'b0, 1'b0);
    cyc();
    bus.res_valid = 1'b0;
    @(negedge clk);
    check("wr_tgt_mismatch", bus.btb_wr, 1);
    cyc();

    // Starvation: fetch reads every cycle, 5 updates, 4 fit
    bus.btb_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_res(1'b1, 31'h0000_0100 + 31'(i), 1'b1, 32'h8000_0000 + 32'(i * 16), 1'b0, '0);
      if (i < 4) push_exp(31'h0000_0100 + 31'(i), 32'h8000_0000 + 32'(i * 16), 1'b0, 1'b1);
      cyc();
    end
    bus.res_valid = 1'b0;
    check("drop_cnt_one", bus.drop_cnt, 1);
    wait_wr(n);
    check("starve_first", n, 4);
    for (int j = 1; j < 4; j++) begin
      wait_wr(n);
      check("starve_gap", n, 8);
    end
    repeat (12) cyc();
    check("starve_drained", exp_q.size(), 0);

    // Flush with 3 queued: never written, full sweep repeats
    for (int i = 0; i < 3; i++) begin
      set_res(1'b1, 31'h0000_0300 + 31'(i), 1'b1, 32'h9000_0000, 1'b0, '0);
      cyc();
    end
    set_res(1'b1, 31'h0000_0400, 1'b1, 32'h9000_0400, 1'b0, '0);
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    bus.res_valid = 1'b0;
    check("flush_init_low", bus.init_done, 0);
    push_sweep(1'b1, 256);
    wait_init(n);
    check("flush_init_cycles", n, 257);
    check("drop_cnt_kept", bus.drop_cnt, 1);
    bus.btb_rd = 1'b0;
    repeat (20) cyc();
    check("flush_drained", exp_q.size(), 0);

    // Reset in the middle of a sweep, at index 100
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    push_sweep(1'b0, 100);
    repeat (101) cyc();
    reset_n = 1'b0;
    #1;
    check("midrst_btb_wr", bus.btb_wr, 0);
    check("midrst_pc_w", bus.pc_w, 0);
    check("midrst_inv", bus.btb_invalid, 0);
    check("midrst_drop_cnt", bus.drop_cnt, 0);
    check("midrst_partial_sweep", exp_q.size(), 0);
    push_sweep(1'b0, 256);
    cyc();
    reset_n = 1'b1;
    wait_init(n);
    check("midrst_init_cycles", n, 257);
    check("midrst_sweep_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_update.md
Name: btb_update

Overview:
- Write-side controller for the branch target buffer; sits in the execute stage.
- Receives resolved branch outcomes, compares each against what fetch predicted, and generates the BTB write and invalidate commands (btb_wr, btb_invalid, pc_w, target_pc_w).
- Buffers pending updates in a small FIFO, arbitrates against fetch reads on the shared single-port BTB memories, and sweeps every entry invalid after reset or on flush.

Parameters:
- TAG_DEPTH, 256, number of BTB entries; index = pc_w[(1+GROUP_WIDTH)+:log2(TAG_DEPTH)].
- GROUP_WIDTH, 1, low PC bits held in the tag; also the index offset.
- FIFO_DEPTH, 4, pending-update entries; power of two, at least 2.
- STARVE_MAX, 8, consecutive fetch-read cycles after which a pending write is forced.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- res_valid  in  1  resolved branch/jump this cycle
- res_pc  in  31 [31:1]  PC of the resolved branch
- res_taken  in  1  branch actually taken
- res_target  in  32  actual target address
- res_pred_hit  in  1  fetch saw btb_hit for this PC
- res_pred_target  in  31 [31:1]  target fetch used on hit
- flush_req  in  1  pulse: clear FIFO and re-sweep the BTB
- btb_rd  in  1  fetch read request, same signal driven to the BTB
- btb_wr  out  1  BTB write strobe
- btb_invalid  out  1  write clears the valid bit
- pc_w  out  31 [31:1]  write PC (index, tag, group)
- target_pc_w  out  32  write target
- wr_conflict  out  1  btb_wr & btb_rd; fetch must treat the next-cycle btb_hit as a miss
- init_done  out  1  sweep complete; fetch ignores btb_hit while 0
- drop_cnt  out  CNT_W  saturating count of updates dropped because the FIFO was full

Behaviour:
- Reset values: state START, FIFO empty, sweep index 0, starve counter 0, drop_cnt 0.
- Reset values of outputs: btb_wr 0, btb_invalid 0, pc_w 0, target_pc_w 0, init_done 0, wr_conflict 0.
- Outputs are combinational from state, sweep index and FIFO head (plus btb_rd for arbitration); BTB write latency is 0 from head to btb_wr.

State START (one cycle):
- btb_wr 0; next state is INIT.

State INIT (sweep):
- Each cycle: btb_wr 1, btb_invalid 1, target_pc_w 0.
- pc_w = index in bits [(1+GROUP_WIDTH)+:log2(TAG_DEPTH)], all other bits 0.
- Sweep writes ignore btb_rd; wr_conflict still reflects btb_wr & btb_rd.
- After index TAG_DEPTH-1: go to RUN and set init_done 1.
- Resolutions arriving in INIT are discarded and not counted.
- flush_req in INIT restarts the index at 0.

State RUN, classification when res_valid=1:
- taken & !pred_hit: push write, btb_invalid 0, target = res_target.
- taken & pred_hit & res_target[31:1] != res_pred_target: push write.
- taken & pred_hit & match: no action.
- !taken & pred_hit: push invalidate, btb_invalid 1, target 0.
- !taken & !pred_hit: no action.

FIFO:
- Entry fields: pc[31:1], target[31:0], inv.
- Push when classification requires an update and (not full, or a pop occurs the same cycle).
- Full with no pop: drop the update and increment drop_cnt, saturating at all-ones.

Drain in RUN:
- btb_wr = !empty & (!btb_rd | starve_cnt == STARVE_MAX).
- Pop on btb_wr. pc_w, target_pc_w and btb_invalid come from the FIFO head.

Starve counter:
- Increments while !empty & btb_rd & !btb_wr, saturating at STARVE_MAX.
- Clears on any pop or when the FIFO is empty.

flush_req in RUN:
- Empty the FIFO, clear the starve counter, go to START, init_done 0.
- An update arriving the same cycle is discarded.
- drop_cnt is retained; only reset clears it.

Ordering: FIFO order is preserved, so a later update to the same index overwrites an earlier one.

Test Plan:
- Reset release, btb_rd=0 → 1 idle cycle, then 256 consecutive btb_wr=1/btb_invalid=1 with pc_w[9:2]=0..255 (pc_w=0x000..0x1FE), init_done=1 on the cycle after the last write.
- RUN, btb_rd=0; res_pc=0x4000_1000>>1, taken, target 0x4000_2000, pred_hit 0 → next cycle btb_wr=1, btb_invalid=0, pc_w=0x2000_0800, target_pc_w=0x4000_2000.
- Not-taken with pred_hit=1 → invalidate write (btb_invalid=1, target_pc_w=0); correctly predicted taken with matching target → no btb_wr.
- btb_rd held 1; push 5 mispredicts in 5 cycles → 4 queued, drop_cnt=1; after 8 read cycles btb_wr=1 with wr_conflict=1, one entry popped per forced write.
- flush_req with 3 entries queued → FIFO empty, init_done=0, full 256-entry sweep repeats, queued entries never written.
- Reset asserted mid-sweep at index 100 → outputs 0 immediately; after release the sweep restarts at index 0.
